// File: rtl/mmio_memory_controller_pkg.sv
// Shared types and constants for the eLC-3 memory/I-O controller:
// FSM state encoding, I/O register offsets and status bit positions.
package mmio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IO,
    S_ACCESS,
    S_HOLD,
    S_DONE
  } state_e;

  // Word offsets inside the I/O window
  localparam logic [2:0] KBSR_OFS = 3'd0;
  localparam logic [2:0] KBDR_OFS = 3'd2;
  localparam logic [2:0] DSR_OFS  = 3'd4;
  localparam logic [2:0] DDR_OFS  = 3'd6;

  localparam int ST_READY = 15;
  localparam int ST_IE    = 14;
  localparam int ST_OVF   = 13;

endpackage

// File: rtl/mmio_memory_controller_kbd_fifo.sv
// Keyboard character FIFO. Pointers carry one extra wrap bit so full and
// empty are told apart without a separate occupancy counter.
module kbd_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
  logic              do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  // A push into a full FIFO is legal when the head leaves in the same cycle
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/mmio_memory_controller.sv
// eLC-3 memory and I/O controller: CPU transactions to async SRAM with
// programmable strobe width, plus keyboard/display device registers.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for Req; latches SRAM address/data on an SRAM hit
//   S_IO     | device register read/write takes effect at the exit edge
//   S_ACCESS | SRAM strobes active; one setup cycle, then WAIT_STATES cycles
//   S_HOLD   | write only: WE_N released, address/data still driven
//   S_DONE   | Ready pulse, back to idle
module mmio_memory_controller
  import mmio_pkg::*;
#(
  parameter int               DATA_W      = 16,
  parameter int               ADDR_W      = 16,
  parameter int               SRAM_ADDR_W = 20,
  parameter int               WAIT_STATES = 2,
  parameter logic [ADDR_W-1:0] IO_BASE    = 16'hFE00,
  parameter int               KBD_DEPTH   = 4
) (
  input  logic                   Clk,
  input  logic                   Reset_N,
  input  logic                   Req,
  input  logic                   R_W,
  input  logic [ADDR_W-1:0]      Address,
  input  logic [DATA_W-1:0]      Data_FromCPU,
  output logic [DATA_W-1:0]      Data_ToCPU,
  output logic                   Ready,
  input  logic                   Kbd_Valid,
  input  logic [DATA_W-1:0]      Kbd_Data,
  output logic [DATA_W-1:0]      Video_Data,
  output logic                   Video_Valid,
  input  logic                   Video_Ack,
  output logic                   Kbd_Irq,
  output logic                   Dsp_Irq,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_UB_N,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0]      SRAM_DQ
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  state_e                 state_q;
  logic [3:0]             wcnt_q;
  logic                   ready_q, ce_n_q, oe_n_q, we_n_q, dq_oe_q;
  logic [DATA_W-1:0]      rdata_q, wdata_q;
  logic [SRAM_ADDR_W-1:0] sram_addr_q;

  logic                   kbd_ie_q, kbd_ovf_q, dsp_ie_q, dsp_ovf_q;
  logic                   vid_valid_q, kbd_irq_q, dsp_irq_q;
  logic [DATA_W-1:0]      vid_data_q;

  logic [ADDR_W-1:0]      io_ofs_full;
  logic [2:0]             io_ofs;
  logic                   io_hit, io_rd, io_wr;
  logic                   kbsr_wr, dsr_wr, ddr_wr, kbdr_rd;
  logic                   fifo_full, fifo_empty, fifo_pop, fifo_push, kbd_ovf_set;
  logic [DATA_W-1:0]      fifo_head, io_rdata_d;

  // Only the four even offsets decode to I/O; everything else is SRAM
  assign io_ofs_full = Address - IO_BASE;
  assign io_ofs      = io_ofs_full[2:0];
  assign io_hit      = (io_ofs_full < ADDR_W'(8)) && !io_ofs_full[0];

  assign io_wr   = (state_q == S_IO) &&  R_W;
  assign io_rd   = (state_q == S_IO) && !R_W;
  assign kbsr_wr = io_wr && (io_ofs == KBSR_OFS);
  assign dsr_wr  = io_wr && (io_ofs == DSR_OFS);
  assign ddr_wr  = io_wr && (io_ofs == DDR_OFS);
  assign kbdr_rd = io_rd && (io_ofs == KBDR_OFS);

  assign fifo_pop    = kbdr_rd & ~fifo_empty;
  assign fifo_push   = Kbd_Valid & (~fifo_full | fifo_pop);
  assign kbd_ovf_set = Kbd_Valid & fifo_full & ~fifo_pop;

  kbd_fifo #(.DATA_W(DATA_W), .DEPTH(KBD_DEPTH)) u_kbd_fifo (
    .clk_i   (Clk),
    .rst_n_i (Reset_N),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (Kbd_Data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  always_comb begin
    io_rdata_d = '0;
    case (io_ofs)
      KBSR_OFS: begin
        io_rdata_d[ST_READY] = ~fifo_empty;
        io_rdata_d[ST_IE]    = kbd_ie_q;
        io_rdata_d[ST_OVF]   = kbd_ovf_q;
      end
      KBDR_OFS: if (!fifo_empty) io_rdata_d = fifo_head;
      DSR_OFS: begin
        io_rdata_d[ST_READY] = ~vid_valid_q;
        io_rdata_d[ST_IE]    = dsp_ie_q;
        io_rdata_d[ST_OVF]   = dsp_ovf_q;
      end
      default: io_rdata_d = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      kbd_ie_q    <= 1'b0;
      kbd_ovf_q   <= 1'b0;
      dsp_ie_q    <= 1'b0;
      dsp_ovf_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      kbd_irq_q   <= 1'b0;
      dsp_irq_q   <= 1'b0;
    end else begin
      if (kbsr_wr) begin
        kbd_ie_q <= Data_FromCPU[ST_IE];
        if (Data_FromCPU[ST_OVF]) kbd_ovf_q <= 1'b0;
      end
      if (kbd_ovf_set) kbd_ovf_q <= 1'b1;
      if (dsr_wr) begin
        dsp_ie_q <= Data_FromCPU[ST_IE];
        if (Data_FromCPU[ST_OVF]) dsp_ovf_q <= 1'b0;
      end
      // An ack in the same cycle frees the slot for the incoming character
      if (ddr_wr) begin
        if (!vid_valid_q || Video_Ack) begin
          vid_data_q  <= Data_FromCPU;
          vid_valid_q <= 1'b1;
        end else begin
          dsp_ovf_q <= 1'b1;
        end
      end else if (Video_Ack) begin
        vid_valid_q <= 1'b0;
      end
      kbd_irq_q <= ~fifo_empty & kbd_ie_q;
      dsp_irq_q <= ~vid_valid_q & dsp_ie_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      wdata_q     <= '0;
      sram_addr_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: if (Req) begin
          if (io_hit) begin
            state_q <= S_IO;
          end else begin
            sram_addr_q <= SRAM_ADDR_W'(Address);
            wdata_q     <= Data_FromCPU;
            wcnt_q      <= WAIT_CNT;
            ce_n_q      <= 1'b0;
            oe_n_q      <= R_W;
            dq_oe_q     <= R_W;
            state_q     <= S_ACCESS;
          end
        end
        S_IO: begin
          if (!R_W) rdata_q <= io_rdata_d;
          ready_q <= 1'b1;
          state_q <= S_DONE;
        end
        // First ACCESS cycle is address setup; WE_N then spans WAIT_STATES cycles
        S_ACCESS: begin
          if (wcnt_q == 4'd0) begin
            oe_n_q <= 1'b1;
            we_n_q <= 1'b1;
            if (R_W) begin
              state_q <= S_HOLD;
            end else begin
              rdata_q <= SRAM_DQ;
              ce_n_q  <= 1'b1;
              ready_q <= 1'b1;
              state_q <= S_DONE;
            end
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
            we_n_q <= ~R_W;
          end
        end
        S_HOLD: begin
          ce_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign SRAM_DQ     = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign SRAM_CE_N   = ce_n_q;
  assign SRAM_LB_N   = ce_n_q;
  assign SRAM_UB_N   = ce_n_q;
  assign SRAM_OE_N   = oe_n_q;
  assign SRAM_WE_N   = we_n_q;
  assign SRAM_ADDR   = sram_addr_q;
  assign Ready       = ready_q;
  assign Data_ToCPU  = rdata_q;
  assign Video_Data  = vid_data_q;
  assign Video_Valid = vid_valid_q;
  assign Kbd_Irq     = kbd_irq_q;
  assign Dsp_Irq     = dsp_irq_q;

endmodule
